// File: rtl/hc05_spi_master_if.sv
// hc05_spi_master_if: 6805 register-bus connection for the $000A-$000C SPI block.
//   bus_sel  : address decoded into the SPI window (wrapper decode)
//   bus_addr : 0=SPCR 1=SPSR 2=SPDR 3=unused
//   bus_wr   : write strobe, active-high
//   bus_din  : write data from the core
//   bus_dout : read data back to the core
// master modport = CPU/wrapper side, slave modport = SPI block side.
interface hc05_spi_master_if;
  logic       bus_sel;
  logic [1:0] bus_addr;
  logic       bus_wr;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;

  modport master (output bus_sel, output bus_addr, output bus_wr, output bus_din,
                  input  bus_dout);
  modport slave  (input  bus_sel, input  bus_addr, input  bus_wr, input  bus_din,
                  output bus_dout);
endinterface

// File: rtl/hc05_spi_master.sv
// hc05_spi_master: 68HC05-style SPI master (SPCR/SPSR/SPDR at $000A-$000C).
// One SPDR write shifts one byte out on mosi (MSB first) and one byte in from miso.
// Ports:
//   clk30  : system clock
//   reset  : synchronous active-high reset
//   clken  : 6805 E-clock enable, all state advances only when high
//   bus    : register bus (slave modport of hc05_spi_master_if)
//   sck    : SPI clock, idles at CPOL
//   mosi   : serial data out
//   miso   : serial data in (already synchronised by the wrapper)
//   ss_n   : slave-select input, low while master-enabled signals a mode fault
//   irq    : SPIE & (SPIF | MODF), level
module hc05_spi_master #(
  parameter int unsigned DIV0 = 2,
  parameter int unsigned DIV1 = 4,
  parameter int unsigned DIV2 = 16,
  parameter int unsigned DIV3 = 32
) (
  input  logic                     clk30,
  input  logic                     reset,
  input  logic                     clken,
  hc05_spi_master_if.slave         bus,
  output logic                     sck,
  output logic                     mosi,
  input  logic                     miso,
  input  logic                     ss_n,
  output logic                     irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Half SCK period minus one, as terminal count for hcnt.
  localparam logic [7:0] HALF0 = 8'(DIV0 / 2 - 1);
  localparam logic [7:0] HALF1 = 8'(DIV1 / 2 - 1);
  localparam logic [7:0] HALF2 = 8'(DIV2 / 2 - 1);
  localparam logic [7:0] HALF3 = 8'(DIV3 / 2 - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] spcr_q, spcr_d;
  logic       spif_q, spif_d;
  logic       wcol_q, wcol_d;
  logic       modf_q, modf_d;
  logic       arm_q, arm_d;
  logic [7:0] rxbuf_q, rxbuf_d;
  logic [7:0] shreg_q, shreg_d;
  logic       rbit_q, rbit_d;
  logic [3:0] ecnt_q, ecnt_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] half_q, half_d;
  logic       cpha_q, cpha_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;

  logic acc, spcr_wr, spsr_rd, spdr_acc, spdr_wr, run_ok;

  always_comb begin
    state_d  = state_q;
    spcr_d   = spcr_q;
    spif_d   = spif_q;
    wcol_d   = wcol_q;
    modf_d   = modf_q;
    arm_d    = arm_q;
    rxbuf_d  = rxbuf_q;
    shreg_d  = shreg_q;
    rbit_d   = rbit_q;
    ecnt_d   = ecnt_q;
    hcnt_d   = hcnt_q;
    half_d   = half_q;
    cpha_d   = cpha_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    acc      = clken & bus.bus_sel;
    spcr_wr  = acc & bus.bus_wr & (bus.bus_addr == 2'd0);
    spsr_rd  = acc & ~bus.bus_wr & (bus.bus_addr == 2'd1);
    spdr_acc = acc & (bus.bus_addr == 2'd2);
    spdr_wr  = spdr_acc & bus.bus_wr;
    run_ok   = 1'b0;

    if (clken) begin
      // Flag-clear latch: armed by an SPSR read that saw a flag, consumed by
      // the next access. Flag sets below are ordered after, so set wins.
      if (arm_q && spdr_acc) begin
        spif_d = 1'b0;
        wcol_d = 1'b0;
      end
      if (arm_q && spcr_wr) modf_d = 1'b0;
      if (acc) arm_d = spsr_rd & (spif_q | wcol_q | modf_q);

      if (spcr_wr) spcr_d = bus.bus_din & 8'hDF;
      if (!ss_n && spcr_q[6] && spcr_q[4]) begin
        modf_d    = 1'b1;
        spcr_d[6] = 1'b0;
        spcr_d[4] = 1'b0;
      end
      run_ok = spcr_d[6] & spcr_d[4];

      unique case (state_q)
        ST_IDLE: begin
          if (spdr_wr && run_ok) begin
            shreg_d = bus.bus_din;
            ecnt_d  = '0;
            hcnt_d  = '0;
            cpha_d  = spcr_d[2];
            sck_d   = spcr_d[3];
            state_d = ST_XFER;
            unique case (spcr_d[1:0])
              2'd0:    half_d = HALF0;
              2'd1:    half_d = HALF1;
              2'd2:    half_d = HALF2;
              default: half_d = HALF3;
            endcase
            if (!spcr_d[2]) mosi_d = bus.bus_din[7];
          end
        end
        ST_XFER: begin
          if (spdr_wr) wcol_d = 1'b1;
          if (!run_ok) begin
            state_d = ST_IDLE;
          end else if (hcnt_q == half_q) begin
            hcnt_d = '0;
            sck_d  = ~sck_q;
            ecnt_d = ecnt_q + 4'd1;
            // Sampled bit waits in rbit until the shift edge so the
            // outgoing LSB is not overwritten before it is sent.
            if (ecnt_q[0] == cpha_q) begin
              if (ecnt_q == 4'd15) shreg_d = {shreg_q[6:0], miso};
              else                 rbit_d  = miso;
            end else if (ecnt_q == 4'd0) begin
              mosi_d = shreg_q[7];
            end else begin
              shreg_d = {shreg_q[6:0], rbit_q};
              if (ecnt_q != 4'd15) mosi_d = shreg_q[6];
            end
            if (ecnt_q == 4'd15) state_d = ST_DONE;
          end else begin
            hcnt_d = hcnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          rxbuf_d = shreg_q;
          spif_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk30) begin
    if (reset) begin
      state_q <= ST_IDLE;
      spcr_q  <= '0;
      spif_q  <= 1'b0;
      wcol_q  <= 1'b0;
      modf_q  <= 1'b0;
      arm_q   <= 1'b0;
      rxbuf_q <= '0;
      shreg_q <= '0;
      rbit_q  <= 1'b0;
      ecnt_q  <= '0;
      hcnt_q  <= '0;
      half_q  <= '0;
      cpha_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      spcr_q  <= spcr_d;
      spif_q  <= spif_d;
      wcol_q  <= wcol_d;
      modf_q  <= modf_d;
      arm_q   <= arm_d;
      rxbuf_q <= rxbuf_d;
      shreg_q <= shreg_d;
      rbit_q  <= rbit_d;
      ecnt_q  <= ecnt_d;
      hcnt_q  <= hcnt_d;
      half_q  <= half_d;
      cpha_q  <= cpha_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  // Outside XFER sck follows the live CPOL bit.
  assign sck  = (state_q == ST_XFER) ? sck_q : spcr_q[3];
  assign mosi = mosi_q;
  assign irq  = spcr_q[7] & (spif_q | modf_q);

  always_comb begin
    unique case (bus.bus_addr)
      2'd0:    bus.bus_dout = spcr_q;
      2'd1:    bus.bus_dout = {spif_q, wcol_q, 1'b0, modf_q, 4'b0000};
      2'd2:    bus.bus_dout = rxbuf_q;
      default: bus.bus_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_hc05_spi_master.sv
module tb_hc05_spi_master;
  logic clk30 = 1'b0;
  logic reset, clken, sck, mosi, miso, ss_n, irq;

  hc05_spi_master_if bus ();

  hc05_spi_master #(.DIV0(2), .DIV1(4), .DIV2(16), .DIV3(32)) dut (
    .clk30 (clk30),
    .reset (reset),
    .clken (clken),
    .bus   (bus),
    .sck   (sck),
    .mosi  (mosi),
    .miso  (miso),
    .ss_n  (ss_n),
    .irq   (irq)
  );

  always #5 clk30 = ~clk30;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: shifts slv_tx out on miso and captures mosi on sample edges.
  logic [7:0] slv_tx, slv_rx;
  logic       slv_cpha;
  logic       slv_on = 1'b0;
  int         slv_edges;

  always @(sck) begin
    if (slv_on) begin
      if (slv_edges[0] == slv_cpha) begin
        slv_rx = {slv_rx[6:0], mosi};
      end else begin
        int idx;
        idx = slv_cpha ? slv_edges / 2 : (slv_edges + 1) / 2;
        if (idx < 8) miso = slv_tx[7 - idx];
      end
      slv_edges++;
    end
  end

  task automatic slv_start(input logic [7:0] tx, input logic cpha);
    slv_tx    = tx;
    slv_cpha  = cpha;
    slv_rx    = '0;
    slv_edges = 0;
    miso      = tx[7];
    slv_on    = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk30);
    bus.bus_sel = 1'b1; bus.bus_wr = 1'b1; bus.bus_addr = a; bus.bus_din = d;
    @(negedge clk30);
    bus.bus_sel = 1'b0; bus.bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk30);
    bus.bus_sel = 1'b1; bus.bus_wr = 1'b0; bus.bus_addr = a;
    #1 d = bus.bus_dout;
    @(negedge clk30);
    bus.bus_sel = 1'b0;
  endtask

  // Side-effect-free look at a register: no clock edge with bus_sel high.
  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    bus.bus_addr = a;
    #1 d = bus.bus_dout;
  endtask

  logic [7:0] d;

  initial begin
    reset = 1'b1; clken = 1'b1; ss_n = 1'b1; miso = 1'b0;
    bus.bus_sel = 1'b0; bus.bus_wr = 1'b0; bus.bus_addr = 2'd0; bus.bus_din = 8'h00;
    repeat (3) @(negedge clk30);
    reset = 1'b0;
    @(negedge clk30);

    peek(2'd0, d); check("rst_spcr", d, 8'h00);
    peek(2'd1, d); check("rst_spsr", d, 8'h00);
    peek(2'd2, d); check("rst_spdr", d, 8'h00);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_irq", irq, 1'b0);

    // 1: div2 mode 0, DD out, EE in
    bus_write(2'd0, 8'h50);
    slv_start(8'hEE, 1'b0);
    bus_write(2'd2, 8'hDD);
    repeat (16) @(negedge clk30);
    peek(2'd1, d); check("t1_spif_at16", d, 8'h00);
    peek(2'd2, d); check("t1_done_old_rx", d, 8'h00);
    @(negedge clk30);
    peek(2'd1, d); check("t1_spif_at17", d, 8'h80);
    peek(2'd2, d); check("t1_rx", d, 8'hEE);
    check("t1_mosi", slv_rx, 8'hDD);
    check("t1_edges", slv_edges, 16);
    check("t1_sck_idle", sck, 1'b0);
    bus_read(2'd1, d); check("t1_spsr_rd", d, 8'h80);
    bus_read(2'd2, d);
    peek(2'd1, d); check("t1_cleared", d, 8'h00);

    // 2: div32, CPOL=1 CPHA=1, A5 out, 3C in
    bus_write(2'd0, 8'h5F);
    check("t2_sck_idle_hi", sck, 1'b1);
    slv_start(8'h3C, 1'b1);
    bus_write(2'd2, 8'hA5);
    repeat (15) @(negedge clk30);
    check("t2_sck_before_e0", sck, 1'b1);
    @(negedge clk30);
    check("t2_sck_after_e0", sck, 1'b0);
    repeat (240) @(negedge clk30);
    peek(2'd1, d); check("t2_spif_at256", d, 8'h00);
    @(negedge clk30);
    peek(2'd1, d); check("t2_spif_at257", d, 8'h80);
    peek(2'd2, d); check("t2_rx", d, 8'h3C);
    check("t2_mosi", slv_rx, 8'hA5);
    check("t2_edges", slv_edges, 16);
    check("t2_sck_end", sck, 1'b1);
    bus_read(2'd1, d);
    bus_read(2'd2, d);

    // 3: write collision during a div16 mode-0 transfer
    bus_write(2'd0, 8'h52);
    slv_start(8'h96, 1'b0);
    bus_write(2'd2, 8'hC3);
    repeat (20) @(negedge clk30);
    bus_write(2'd2, 8'h11);
    peek(2'd1, d); check("t3_wcol", d, 8'h40);
    repeat (120) @(negedge clk30);
    check("t3_mosi", slv_rx, 8'hC3);
    bus_read(2'd1, d); check("t3_spsr_c0", d, 8'hC0);
    bus_read(2'd2, d); check("t3_rx", d, 8'h96);
    peek(2'd1, d); check("t3_cleared", d, 8'h00);

    // 4: interrupt and clear sequence
    bus_write(2'd0, 8'hD0);
    check("t4_irq_idle", irq, 1'b0);
    slv_start(8'h81, 1'b0);
    bus_write(2'd2, 8'h3E);
    repeat (16) @(negedge clk30);
    check("t4_irq_at16", irq, 1'b0);
    @(negedge clk30);
    check("t4_irq_at17", irq, 1'b1);
    peek(2'd2, d); check("t4_rx", d, 8'h81);
    bus_read(2'd1, d);
    bus_write(2'd0, 8'hD0);
    peek(2'd1, d); check("t4_spcr_wr_keeps_spif", d, 8'h80);
    check("t4_irq_kept", irq, 1'b1);
    bus_read(2'd1, d);
    bus_read(2'd2, d);
    check("t4_irq_cleared", irq, 1'b0);
    peek(2'd1, d); check("t4_spsr_cleared", d, 8'h00);

    // 5: mode fault mid-transfer
    slv_start(8'hFF, 1'b0);
    bus_write(2'd2, 8'hF0);
    repeat (5) @(negedge clk30);
    ss_n = 1'b0;
    @(negedge clk30);
    peek(2'd1, d); check("t5_modf", d, 8'h10);
    peek(2'd0, d); check("t5_spcr", d, 8'h80);
    check("t5_sck", sck, 1'b0);
    check("t5_irq", irq, 1'b1);
    ss_n = 1'b1;
    repeat (20) @(negedge clk30);
    peek(2'd1, d); check("t5_spif_stays0", d, 8'h10);
    peek(2'd2, d); check("t5_rx_unchanged", d, 8'h81);
    bus_read(2'd1, d); check("t5_spsr_rd", d, 8'h10);
    bus_write(2'd0, 8'h50);
    peek(2'd1, d); check("t5_modf_cleared", d, 8'h00);
    peek(2'd0, d); check("t5_spcr_new", d, 8'h50);

    // SPDR write with SPE=0 is dropped
    bus_write(2'd0, 8'h10);
    bus_write(2'd2, 8'hFF);
    repeat (20) @(negedge clk30);
    peek(2'd1, d); check("drop_spsr", d, 8'h00);
    check("drop_sck", sck, 1'b0);

    // 6: reset at edge 7, with clken low
    bus_write(2'd0, 8'h50);
    slv_start(8'h00, 1'b0);
    bus_write(2'd2, 8'h77);
    repeat (7) @(negedge clk30);
    check("t6_pre_sck", sck, 1'b1);
    check("t6_pre_mosi", mosi, 1'b1);
    reset = 1'b1; clken = 1'b0;
    @(negedge clk30);
    check("t6_sck", sck, 1'b0);
    check("t6_mosi", mosi, 1'b0);
    check("t6_irq", irq, 1'b0);
    peek(2'd0, d); check("t6_spcr", d, 8'h00);
    peek(2'd1, d); check("t6_spsr", d, 8'h00);
    peek(2'd2, d); check("t6_spdr", d, 8'h00);
    reset = 1'b0; clken = 1'b1;
    bus_write(2'd0, 8'h50);
    slv_start(8'hA7, 1'b0);
    bus_write(2'd2, 8'h5A);
    repeat (17) @(negedge clk30);
    peek(2'd1, d); check("t6_new_spif", d, 8'h80);
    peek(2'd2, d); check("t6_new_rx", d, 8'hA7);
    check("t6_new_mosi", slv_rx, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
